// File: rtl/jts16_buswait.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : jts16_buswait                                               |
// | Purpose  : DTACKn/BERRn generator for the 68000 main bus with          |
// |            per-channel wait states, ok handshake and bus timeout.     |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module jts16_buswait #(
    parameter int CH      = 4,
    parameter int WAITW   = 3,
    parameter int TOW     = 8,
    parameter int TIMEOUT = 200,
    parameter int DEF_ACK = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_cen,
    input  logic                cpu_cenb,
    input  logic                ASn,
    input  logic [CH-1:0]       cs,
    input  logic [CH*WAITW-1:0] wait_cfg,
    input  logic [CH-1:0]       hs_en,
    input  logic [CH-1:0]       ok,
    output logic                DTACKn,
    output logic                BERRn,
    output logic [CH-1:0]       ack_ch,
    output logic                busy
);

    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_WAIT   = 3'd1;
    localparam logic [2:0] c_NOCS   = 3'd2;
    localparam logic [2:0] c_OKWAIT = 3'd3;
    localparam logic [2:0] c_ACK    = 3'd4;
    localparam logic [2:0] c_ERR    = 3'd5;

    localparam logic [TOW-1:0] c_TIMEOUT = TOW'(TIMEOUT);

    logic [2:0]       r_state, w_state;
    logic [CHW-1:0]   r_ch, w_ch;
    logic [WAITW-1:0] r_wcnt, w_wcnt;
    logic [TOW-1:0]   r_tcnt, w_tcnt;
    logic             r_qual, w_qual;
    logic             r_nohs, w_nohs;
    logic             r_dtackn, w_dtackn;
    logic             r_berrn, w_berrn;
    logic [CH-1:0]    r_ack, w_ack;

    logic [CHW-1:0]   w_sel;
    logic [WAITW-1:0] w_cfg;
    logic [TOW-1:0]   w_tinc;
    logic             w_tout;
    logic             w_okack;
    logic             w_ack_now;
    logic             w_adv;
    logic             w_unused;

    // phi2 enable is reserved for future sequencing
    assign w_unused = cpu_cenb;

    // Lowest-index active chip select wins
    always_comb begin
        w_sel = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (cs[i]) w_sel = CHW'(i);
        end
    end

    assign w_cfg   = wait_cfg[int'(w_sel)*WAITW +: WAITW];
    assign w_tinc  = (&r_tcnt) ? r_tcnt : r_tcnt + TOW'(1);
    assign w_tout  = (TIMEOUT != 0) && (w_tinc == c_TIMEOUT);
    // Qualify flag masks an ok left high by the previous access
    assign w_okack = !r_nohs && (!hs_en[r_ch] || (ok[r_ch] && r_qual));

    always_comb begin
        w_state   = r_state;
        w_ch      = r_ch;
        w_wcnt    = r_wcnt;
        w_tcnt    = r_tcnt;
        w_qual    = r_qual;
        w_nohs    = r_nohs;
        w_dtackn  = r_dtackn;
        w_berrn   = r_berrn;
        w_ack     = r_ack;
        w_ack_now = 1'b0;
        w_adv     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!ASn) begin
                    w_tcnt = '0;
                    w_qual = 1'b0;
                    w_nohs = 1'b0;
                    if (|cs) begin
                        w_ch    = w_sel;
                        w_wcnt  = w_cfg;
                        w_state = c_WAIT;
                    end else if (DEF_ACK != 0) begin
                        w_ch    = '0;
                        w_wcnt  = WAITW'(1);
                        w_state = c_NOCS;
                    end else begin
                        w_ch    = '0;
                        w_nohs  = 1'b1;
                        w_state = c_OKWAIT;
                    end
                end
            end
            c_WAIT, c_NOCS, c_OKWAIT: begin
                if (r_state == c_OKWAIT) w_qual = 1'b1;
                if (ASn) begin
                    w_state = c_IDLE;
                end else if (cpu_cen) begin
                    w_tcnt = w_tinc;
                    if (r_state == c_OKWAIT) begin
                        w_ack_now = w_okack;
                    end else if (r_wcnt != '0) begin
                        w_wcnt = r_wcnt - WAITW'(1);
                    end else if (r_state == c_NOCS || !hs_en[r_ch]) begin
                        // No handshake: acknowledge on the expiring tick itself
                        w_ack_now = 1'b1;
                    end else begin
                        w_adv = 1'b1;
                    end
                    if (w_ack_now) begin
                        w_dtackn = 1'b0;
                        w_ack    = (r_state == c_NOCS) ? '0 : (CH'(1) << r_ch);
                        w_state  = c_ACK;
                    end else if (w_tout) begin
                        w_berrn = 1'b0;
                        w_state = c_ERR;
                    end else if (w_adv) begin
                        w_qual  = 1'b0;
                        w_state = c_OKWAIT;
                    end
                end
            end
            c_ACK: begin
                if (ASn) begin
                    w_dtackn = 1'b1;
                    w_ack    = '0;
                    w_state  = c_IDLE;
                end
            end
            c_ERR: begin
                if (ASn) begin
                    w_berrn = 1'b1;
                    w_state = c_IDLE;
                end
            end
            default: w_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_ch     <= '0;
            r_wcnt   <= '0;
            r_tcnt   <= '0;
            r_qual   <= 1'b0;
            r_nohs   <= 1'b0;
            r_dtackn <= 1'b1;
            r_berrn  <= 1'b1;
            r_ack    <= '0;
        end else begin
            r_state  <= w_state;
            r_ch     <= w_ch;
            r_wcnt   <= w_wcnt;
            r_tcnt   <= w_tcnt;
            r_qual   <= w_qual;
            r_nohs   <= w_nohs;
            r_dtackn <= w_dtackn;
            r_berrn  <= w_berrn;
            r_ack    <= w_ack;
        end
    end

    assign DTACKn = r_dtackn;
    assign BERRn  = r_berrn;
    assign ack_ch = r_ack;
    assign busy   = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_jts16_buswait.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_jts16_buswait                                            |
// | Purpose  : Scoreboard bench for jts16_buswait (DEF_ACK=1 and 0 units). |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module tb_jts16_buswait;

    logic        clk = 1'b0, rst = 1'b1, cpu_cen = 1'b0, cpu_cenb = 1'b0, ASn = 1'b1;
    logic [3:0]  cs = '0, hs_en = '0, ok = '0;
    logic [11:0] wait_cfg = '0;
    logic        dt0, be0, busy0, dt1, be1, busy1;
    logic [3:0]  ack0, ack1;

    int cmp = 0, err = 0, ncen = 0, ph = 0;

    typedef struct {
        int         cens;
        logic [3:0] ack;
        logic       berr;
    } exp_t;
    exp_t sb[$];

    jts16_buswait #(.CH(4), .WAITW(3), .TOW(8), .TIMEOUT(10), .DEF_ACK(1)) u0 (
        .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .cpu_cenb(cpu_cenb), .ASn(ASn),
        .cs(cs), .wait_cfg(wait_cfg), .hs_en(hs_en), .ok(ok),
        .DTACKn(dt0), .BERRn(be0), .ack_ch(ack0), .busy(busy0)
    );

    jts16_buswait #(.CH(4), .WAITW(3), .TOW(8), .TIMEOUT(10), .DEF_ACK(0)) u1 (
        .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .cpu_cenb(cpu_cenb), .ASn(ASn),
        .cs(cs), .wait_cfg(wait_cfg), .hs_en(hs_en), .ok(ok),
        .DTACKn(dt1), .BERRn(be1), .ack_ch(ack1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic step(input logic c);
        @(negedge clk);
        cpu_cen = c;
        @(posedge clk);
        #1;
        if (c) ncen++;
    endtask

    task automatic tick();
        step(ph == 2);
        ph = (ph + 1) % 3;
    endtask

    task automatic start(input logic [3:0] c);
        ASn = 1'b0;
        cs  = c;
        step(1'b0);
        ncen = 0;
        ph   = 0;
    endtask

    task automatic wait_resp(input int sel, input string nm);
        exp_t       e;
        logic       hit;
        int         g;
        logic [3:0] a;
        logic [1:0] got, req;
        hit = 1'b0;
        g   = 0;
        while (!hit && g < 500) begin
            tick();
            g++;
            hit = (sel != 0) ? (!dt1 || !be1) : (!dt0 || !be0);
        end
        e = sb.pop_front();
        cmp++;
        if (!hit) begin
            $display("FAIL %s_resp: no response after %0d clks, required one at cen %0d", nm, g, e.cens);
            err++;
        end else begin
            a   = (sel != 0) ? ack1 : ack0;
            got = (sel != 0) ? {dt1, be1} : {dt0, be0};
            req = e.berr ? 2'b10 : 2'b01;
            cmp++;
            if (ncen !== e.cens) begin
                $display("FAIL %s_latency: got cen %0d, required %0d", nm, ncen, e.cens);
                err++;
            end
            cmp++;
            if (a !== e.ack) begin
                $display("FAIL %s_ack_ch: got %b, required %b", nm, a, e.ack);
                err++;
            end
            cmp++;
            if (got !== req) begin
                $display("FAIL %s_kind: got DTACKn,BERRn=%b, required %b", nm, got, req);
                err++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step(1'b0);
        cmp++;
        if ({dt0, be0, ack0, busy0} !== 7'b11_0000_0) begin
            $display("FAIL reset_u0: got %b, required 1100000", {dt0, be0, ack0, busy0});
            err++;
        end
        cmp++;
        if ({dt1, be1, ack1, busy1} !== 7'b11_0000_0) begin
            $display("FAIL reset_u1: got %b, required 1100000", {dt1, be1, ack1, busy1});
            err++;
        end
        rst = 1'b0;
        step(1'b0);
    endtask

    task automatic test_wait_latency();
        wait_cfg = {3'd0, 3'd3, 3'd0, 3'd0};
        hs_en    = '0;
        sb.push_back('{4, 4'b0100, 1'b0});
        start(4'b0100);
        cs = 4'b0001;
        wait_resp(0, "ch2_wait3");
        ASn = 1'b1;
        step(1'b0);
        cmp++;
        if ({dt0, ack0, busy0} !== 6'b1_0000_0) begin
            $display("FAIL ch2_release: got %b, required 100000", {dt0, ack0, busy0});
            err++;
        end
        cs = '0;
    endtask

    task automatic test_handshake();
        wait_cfg = '0;
        hs_en    = 4'b0001;
        ok       = 4'b0001;
        ASn      = 1'b0;
        cs       = 4'b0001;
        step(1'b0);
        step(1'b1);
        step(1'b1);
        cmp++;
        if (dt0 !== 1'b1) begin
            $display("FAIL hs_stale_ok: got DTACKn %b, required 1", dt0);
            err++;
        end
        ok = '0;
        repeat (5) begin
            step(1'b0);
            step(1'b0);
            step(1'b1);
        end
        cmp++;
        if (dt0 !== 1'b1) begin
            $display("FAIL hs_ok_low: got DTACKn %b, required 1", dt0);
            err++;
        end
        ok = 4'b0001;
        sb.push_back('{1, 4'b0001, 1'b0});
        ncen = 0;
        ph   = 0;
        wait_resp(0, "hs_ok_rise");
        ASn = 1'b1;
        step(1'b0);
        ok    = '0;
        hs_en = '0;
        cs    = '0;
    endtask

    task automatic test_priority();
        wait_cfg = {3'd5, 3'd0, 3'd1, 3'd0};
        sb.push_back('{2, 4'b0010, 1'b0});
        start(4'b1010);
        wait_resp(0, "prio");
        ASn = 1'b1;
        step(1'b0);
        cmp++;
        if (ack0 !== 4'b0000) begin
            $display("FAIL prio_release: got ack_ch %b, required 0000", ack0);
            err++;
        end
        cs = '0;
    endtask

    task automatic test_timeout();
        wait_cfg = '0;
        hs_en    = 4'b1000;
        ok       = '0;
        sb.push_back('{10, 4'b0000, 1'b1});
        start(4'b1000);
        wait_resp(0, "timeout");
        ASn = 1'b1;
        step(1'b0);
        cmp++;
        if ({be0, busy0} !== 2'b10) begin
            $display("FAIL timeout_release: got BERRn,busy %b, required 10", {be0, busy0});
            err++;
        end
        hs_en = '0;
        cs    = '0;
    endtask

    task automatic test_nocs();
        sb.push_back('{2, 4'b0000, 1'b0});
        start(4'b0000);
        wait_resp(0, "defack1");
        sb.push_back('{10, 4'b0000, 1'b1});
        wait_resp(1, "defack0_timeout");
        ASn = 1'b1;
        step(1'b0);
        cmp++;
        if ({dt0, be1, busy0, busy1} !== 4'b1100) begin
            $display("FAIL nocs_release: got %b, required 1100", {dt0, be1, busy0, busy1});
            err++;
        end
    endtask

    task automatic test_abort();
        int lows;
        wait_cfg = {3'd0, 3'd0, 3'd0, 3'd5};
        start(4'b0001);
        repeat (6) tick();
        ASn = 1'b1;
        step(1'b0);
        cmp++;
        if ({busy0, dt0, be0} !== 3'b011) begin
            $display("FAIL abort_idle: got busy,DTACKn,BERRn %b, required 011", {busy0, dt0, be0});
            err++;
        end
        lows = 0;
        repeat (30) begin
            tick();
            if (!dt0) lows++;
        end
        cmp++;
        if (lows !== 0) begin
            $display("FAIL abort_no_ack: got %0d DTACKn-low clks, required 0", lows);
            err++;
        end
        cs = '0;
    endtask

    task automatic test_rst_ack();
        wait_cfg = {3'd0, 3'd3, 3'd0, 3'd0};
        sb.push_back('{4, 4'b0100, 1'b0});
        start(4'b0100);
        wait_resp(0, "rst_pre");
        cs  = '0;
        rst = 1'b1;
        step(1'b0);
        cmp++;
        if ({dt0, ack0, busy0} !== 6'b1_0000_0) begin
            $display("FAIL rst_in_ack: got %b, required 100000", {dt0, ack0, busy0});
            err++;
        end
        ASn = 1'b1;
        step(1'b0);
        rst = 1'b0;
        step(1'b0);
    endtask

    task automatic test_back_to_back();
        int bad;
        wait_cfg = {3'd0, 3'd0, 3'd2, 3'd0};
        sb.push_back('{3, 4'b0010, 1'b0});
        start(4'b0010);
        wait_resp(0, "b2b_first");
        bad = 0;
        repeat (30) begin
            tick();
            if (dt0 !== 1'b0 || ack0 !== 4'b0010) bad++;
        end
        cmp++;
        if (bad !== 0) begin
            $display("FAIL b2b_hold: got %0d disturbed clks, required 0", bad);
            err++;
        end
        ASn = 1'b1;
        step(1'b0);
        cmp++;
        if (dt0 !== 1'b1) begin
            $display("FAIL b2b_release: got DTACKn %b, required 1", dt0);
            err++;
        end
        sb.push_back('{3, 4'b0010, 1'b0});
        start(4'b0010);
        wait_resp(0, "b2b_second");
        ASn = 1'b1;
        step(1'b0);
        cs = '0;
    endtask

    initial begin
        test_reset();
        test_wait_latency();
        test_handshake();
        test_priority();
        test_timeout();
        test_nocs();
        test_abort();
        test_rst_ack();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
`default_nettype wire
